// File: rtl/fountain_v2_encoder.sv
`default_nettype none
// ============================================================================
// Module   : fountain_v2_encoder
// Brief    : Serial LT/fountain encoder; buffers K symbols, emits LFSR-selected XORs.
// Revision : 2.0
// ============================================================================
module fountain_v2_encoder #(
  parameter int                SYM_W     = 8,
  parameter int                K         = 32,
  parameter int                LFSR_W    = 32,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 32'h80200003,
  parameter int                CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LFSR_W-1:0]        seed,
  input  logic [CNT_W-1:0]         num_out,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SYM_W-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SYM_W-1:0]         out_data,
  output logic [CNT_W-1:0]         out_seq,
  output logic [$clog2(K+1)-1:0]   out_degree,
  output logic                     busy,
  output logic                     done
);

  localparam int                IDX_W    = (K > 1) ? $clog2(K) : 1;
  localparam int                DEG_W    = $clog2(K + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(K - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ENCODE = 3'd2,
    S_OUTPUT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [SYM_W-1:0]   mem_q [K];
  logic [IDX_W-1:0]   wr_idx_q;
  logic [IDX_W-1:0]   j_q;
  logic [IDX_W-1:0]   fb_idx_q;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [CNT_W-1:0]   num_out_q;
  logic [CNT_W-1:0]   out_seq_q;
  logic [SYM_W-1:0]   acc_q;
  logic [SYM_W-1:0]   fallback_q;
  logic [SYM_W-1:0]   out_data_q;
  logic [DEG_W-1:0]   deg_q;
  logic [DEG_W-1:0]   out_degree_q;
  logic               out_valid_q;

  logic               w_in_fire;
  logic               w_out_fire;
  logic [CNT_W-1:0]   w_seq_inc;
  logic [SYM_W-1:0]   w_sym;
  logic               w_sel;
  logic [SYM_W-1:0]   w_acc_nx;
  logic [DEG_W-1:0]   w_deg_nx;
  logic [SYM_W-1:0]   w_fb_nx;
  logic [LFSR_W-1:0]  w_lfsr_nx;

  assign w_in_fire  = in_valid && (state_q == S_LOAD);
  assign w_out_fire = out_valid_q && out_ready;
  assign w_seq_inc  = out_seq_q + CNT_W'(1);
  assign w_sym      = mem_q[j_q];
  assign w_sel      = lfsr_q[0];
  assign w_acc_nx   = acc_q ^ (w_sel ? w_sym : '0);
  assign w_deg_nx   = deg_q + DEG_W'(w_sel);
  // The fallback symbol rotates through the block with the sequence number.
  assign w_fb_nx    = (j_q == fb_idx_q) ? w_sym : fallback_q;
  assign w_lfsr_nx  = (lfsr_q >> 1) ^ (w_sel ? LFSR_TAPS : '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD;
      S_LOAD:   if (w_in_fire && (wr_idx_q == LAST_IDX))
                  state_d = (num_out_q == '0) ? S_DONE : S_ENCODE;
      S_ENCODE: if (j_q == LAST_IDX) state_d = S_OUTPUT;
      S_OUTPUT: if (w_out_fire)
                  state_d = (w_seq_inc == num_out_q) ? S_DONE : S_ENCODE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Source buffer carries no reset; its contents are rewritten every block.
  always_ff @(posedge clk) begin
    if (w_in_fire) mem_q[wr_idx_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_idx_q     <= '0;
      j_q          <= '0;
      fb_idx_q     <= '0;
      lfsr_q       <= LFSR_W'(1);
      num_out_q    <= '0;
      out_seq_q    <= '0;
      acc_q        <= '0;
      fallback_q   <= '0;
      out_data_q   <= '0;
      deg_q        <= '0;
      out_degree_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          wr_idx_q <= '0;
          if (start) begin
            lfsr_q    <= (seed == '0) ? LFSR_W'(1) : seed;
            num_out_q <= num_out;
          end
        end
        S_LOAD: begin
          if (w_in_fire) begin
            wr_idx_q   <= (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + IDX_W'(1);
            j_q        <= '0;
            fb_idx_q   <= '0;
            acc_q      <= '0;
            deg_q      <= '0;
            fallback_q <= '0;
          end
        end
        S_ENCODE: begin
          lfsr_q     <= w_lfsr_nx;
          acc_q      <= w_acc_nx;
          deg_q      <= w_deg_nx;
          fallback_q <= w_fb_nx;
          if (j_q == LAST_IDX) begin
            j_q <= '0;
            if (w_deg_nx == '0) begin
              out_data_q   <= w_fb_nx;
              out_degree_q <= DEG_W'(1);
            end else begin
              out_data_q   <= w_acc_nx;
              out_degree_q <= w_deg_nx;
            end
          end else begin
            j_q <= j_q + IDX_W'(1);
          end
        end
        S_OUTPUT: begin
          // Valid rises one cycle after the result lands in out_data.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            out_seq_q   <= w_seq_inc;
            fb_idx_q    <= (fb_idx_q == LAST_IDX) ? '0 : fb_idx_q + IDX_W'(1);
            j_q         <= '0;
            acc_q       <= '0;
            deg_q       <= '0;
            fallback_q  <= '0;
          end
        end
        S_DONE: begin
          out_seq_q <= '0;
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_seq    = out_seq_q;
  assign out_degree = out_degree_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: doc/fountain_v2_encoder.md
Name: fountain_v2_encoder

Overview:
Parametrised serial LT/fountain encoder, successor to the v1 serial encoder. Buffers one block of K source symbols of SYM_W bits, then produces a run-time programmable number of encoded symbols. Each encoded symbol is the XOR of a pseudo-random subset of the buffered symbols, selected by a seedable Galois LFSR. It sits between the packetiser (valid/ready source stream) and the channel framer (valid/ready encoded stream), and reports sequence number and degree per encoded symbol.

Parameters:
SYM_W, 8, source/encoded symbol width in bits
K, 32, source symbols per block (>=2)
LFSR_W, 32, LFSR width
LFSR_TAPS, 32'h80200003, Galois feedback mask (LFSR_W bits)
CNT_W, 16, width of num_out and out_seq

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin a block; sampled only in IDLE
seed  in  LFSR_W  LFSR seed, captured on accepted start
num_out  in  CNT_W  encoded symbols to emit, captured on accepted start
in_valid  in  1  source symbol valid
in_ready  out  1  encoder accepts source symbol
in_data  in  SYM_W  source symbol
out_valid  out  1  encoded symbol valid
out_ready  in  1  downstream accepts encoded symbol
out_data  out  SYM_W  encoded symbol
out_seq  out  CNT_W  index of encoded symbol within block (0-based)
out_degree  out  $clog2(K+1)  number of source symbols XORed into out_data
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when block finished

Behaviour:
- Reset (synchronous, active-high, from any state, including mid-block): state=IDLE; in_ready, out_valid, busy, done = 0; out_data, out_seq, out_degree = 0; counters cleared; LFSR = 1; buffer contents are don't-care.
- States: IDLE, LOAD, ENCODE, OUTPUT, DONE.
- IDLE: start=1 captures seed (0 replaced by 1) and num_out, then moves to LOAD. start in any other state is ignored.
- LOAD: in_ready=1. Each in_valid&in_ready edge writes in_data to buf[wr_idx] and increments wr_idx (0..K-1). After the K-th accept: go to DONE if num_out==0, else go to ENCODE with j=0, acc=0, deg=0.
- ENCODE: one source symbol per cycle, j = 0..K-1.
  - If lfsr[0]==1: acc ^= buf[j], deg += 1.
  - If j == out_seq mod K: fallback = buf[j].
  - LFSR advances every ENCODE cycle: next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 0).
  - At j=K-1, the result registers into out_data/out_degree and state moves to OUTPUT.
  - Degree-0 rule: if the final deg is 0, out_data = fallback and out_degree = 1.
- Latency: out_valid rises K+1 cycles after the edge accepting the last source symbol, and K+1 cycles after each out handshake.
- OUTPUT: out_valid=1. out_data, out_seq and out_degree are held stable until out_ready. On handshake: out_valid drops next cycle and out_seq increments. If out_seq+1 == num_out, go to DONE; else go to ENCODE (j=0, acc=0, deg=0). The LFSR is not reset between symbols; it runs continuously through the block.
- DONE: done=1 for exactly one cycle, then IDLE. out_seq resets to 0 when entering IDLE.
- out_seq wraps modulo 2^CNT_W; num_out = 2^CNT_W-1 is the maximum.
- No input is consumed outside LOAD. in_valid without in_ready is held by upstream.

Test Plan:
- SYM_W=8, K=4, seed=1, num_out=1, inputs 0x11,0x22,0x44,0x88 -> selection mask {0,1,3}, out_data=0xBB, out_degree=3, out_seq=0, out_valid 5 cycles after last input accept, done pulse one cycle after handshake; final LFSR 0xB02C0003.
- K=2, seed=4, inputs 0xA5,0x5A, num_out=1 -> LFSR bits 0,0 give degree 0, so fallback: out_data=0xA5, out_degree=1.
- K=4, seed=1, num_out=3, out_ready held low 10 cycles on symbol 0 -> out_data/out_seq/out_degree stable throughout; out_seq sequence 0,1,2; outputs match the software Galois LFSR model; exactly one done pulse.
- num_out=0, seed=0 -> four inputs accepted, no out_valid, done pulses one cycle after the 4th accept; captured seed reads back as 1.
- Reset asserted during ENCODE of symbol 1 -> next cycle IDLE, all outputs 0. A new start with the same seed and data reproduces the identical output stream.
- start pulsed during LOAD/ENCODE/OUTPUT -> ignored: num_out and seed unchanged, stream unaffected.
